// File: rtl/bp_gateway_io_splitter_pkg.sv
// Shared types and defaults for the gateway I/O splitter: processor config
// selector, a compact CCE memory message layout, destination encoding and the
// default host MMIO window.
package bp_gateway_io_splitter_pkg;

  typedef enum logic [1:0] {
    e_bp_single_core_cfg = 2'd0,
    e_bp_dual_core_cfg   = 2'd1
  } bp_params_e;

  localparam int unsigned paddr_width_gp       = 40;
  localparam int unsigned msg_data_width_gp    = 64;
  localparam int unsigned msg_payload_width_gp = 8;

  typedef struct packed {
    logic [3:0]                      msg_type;
    logic [2:0]                      size;
    logic [paddr_width_gp-1:0]       addr;
    logic [msg_payload_width_gp-1:0] payload;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    bp_cce_mem_msg_header_s       header;
    logic [msg_data_width_gp-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int unsigned msg_width_gp    = $bits(bp_cce_mem_msg_s);
  // addr sits directly above payload and data in the packed message
  localparam int unsigned msg_addr_lsb_gp = msg_data_width_gp + msg_payload_width_gp;

  typedef enum logic [0:0] {
    e_dest_host = 1'b0,
    e_dest_aux  = 1'b1
  } bp_gateway_io_dest_e;

  localparam logic [paddr_width_gp-1:0] host_base_gp = 40'h00_0010_0000;
  localparam logic [paddr_width_gp-1:0] host_size_gp = 40'h00_0010_0000;

  // Physical address width supplied by each processor configuration.
  function automatic int unsigned paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_single_core_cfg: return paddr_width_gp;
      default:              return paddr_width_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_gateway_io_splitter_tracker.sv
// In-order destination tracker: a circular FIFO of 1-bit destinations.
// With BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN defined it also reports whether any
// live entry targets the host or the aux device.
module bp_gateway_io_splitter_tracker
  import bp_gateway_io_splitter_pkg::*;
#(
  parameter int unsigned els_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enq_v_i,
  input  logic enq_dest_i,
  input  logic deq_v_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
`ifdef BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN
  ,
  output logic entry_host_o,
  output logic entry_aux_o
`endif
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);

  logic [els_p-1:0]    mem;
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [ptr_w_lp-1:0] wr_ptr;
  logic [ptr_w_lp:0]   count;
  logic                enq;
  logic                deq;

  // Status flags and guarded push/pop strobes.
  always_comb begin
    full_o  = (count == (ptr_w_lp+1)'(els_p));
    empty_o = (count == '0);
    enq     = enq_v_i & ~full_o;
    deq     = deq_v_i & ~empty_o;
    head_o  = mem[rd_ptr];
  end

  // Pointer and occupancy update; pointers wrap naturally at els_p.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Destination storage; contents outside the live window are don't-care.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= enq_dest_i;
  end

`ifdef BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN
  logic [ptr_w_lp-1:0] dist;

  // Scan live entries (distance from head below count) for each destination.
  always_comb begin
    entry_host_o = 1'b0;
    entry_aux_o  = 1'b0;
    dist         = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      dist = ptr_w_lp'(i) - rd_ptr;
      if ({1'b0, dist} < count) begin
        if (mem[i] == e_dest_host) entry_host_o = 1'b1;
        else                       entry_aux_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bp_gateway_io_splitter.sv
// Address-decoding I/O splitter: routes chip I/O commands to the host MMIO
// device or the aux device and returns responses strictly in command order.
// Optional protocol checking: BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN.
module bp_gateway_io_splitter
  import bp_gateway_io_splitter_pkg::*;
#(
  parameter bp_params_e                  bp_params_p       = e_bp_single_core_cfg,
  parameter int unsigned                 max_outstanding_p = 4,
  parameter logic [paddr_width_gp-1:0]   host_base_p       = host_base_gp,
  parameter logic [paddr_width_gp-1:0]   host_size_p       = host_size_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [msg_width_gp-1:0] io_cmd_i,
  input  logic                    io_cmd_v_i,
  output logic                    io_cmd_ready_o,

  output logic [msg_width_gp-1:0] io_resp_o,
  output logic                    io_resp_v_o,
  input  logic                    io_resp_yumi_i,

  output logic [msg_width_gp-1:0] host_cmd_o,
  output logic                    host_cmd_v_o,
  input  logic                    host_cmd_ready_i,

  input  logic [msg_width_gp-1:0] host_resp_i,
  input  logic                    host_resp_v_i,
  output logic                    host_resp_yumi_o,

  output logic [msg_width_gp-1:0] aux_cmd_o,
  output logic                    aux_cmd_v_o,
  input  logic                    aux_cmd_ready_i,

  input  logic [msg_width_gp-1:0] aux_resp_i,
  input  logic                    aux_resp_v_i,
  output logic                    aux_resp_yumi_o,

  output logic                    error_o
);

  localparam int unsigned               paddr_width_lp = paddr_width(bp_params_p);
  localparam logic [paddr_width_lp-1:0] host_mask_lp   = ~(host_size_p - 1'b1);

  logic [paddr_width_lp-1:0] cmd_addr;
  bp_gateway_io_dest_e       dest;
  logic                      dest_ready;
  logic                      head;
  logic                      head_host;
  logic                      head_v;
  logic                      full;
  logic                      empty;
  logic                      enq;
  logic                      deq;

  assign cmd_addr = io_cmd_i[msg_addr_lsb_gp +: paddr_width_lp];

  // Destination decode: host window is a naturally aligned power-of-2 region.
  always_comb begin
    dest = ((cmd_addr & host_mask_lp) == host_base_p) ? e_dest_host : e_dest_aux;
  end

  // Command steering; everything is held off while in reset or tracker full.
  always_comb begin
    host_cmd_o     = io_cmd_i;
    aux_cmd_o      = io_cmd_i;
    dest_ready     = (dest == e_dest_host) ? host_cmd_ready_i : aux_cmd_ready_i;
    io_cmd_ready_o = ~reset_i & ~full & dest_ready;
    host_cmd_v_o   = ~reset_i & ~full & io_cmd_v_i & (dest == e_dest_host);
    aux_cmd_v_o    = ~reset_i & ~full & io_cmd_v_i & (dest == e_dest_aux);
    enq            = io_cmd_v_i & io_cmd_ready_o;
  end

  // Response return from whichever device owns the oldest outstanding command.
  always_comb begin
    head_host        = (head == e_dest_host);
    io_resp_o        = head_host ? host_resp_i : aux_resp_i;
    head_v           = head_host ? host_resp_v_i : aux_resp_v_i;
    io_resp_v_o      = ~reset_i & ~empty & head_v;
    host_resp_yumi_o = ~reset_i & ~empty & head_host & io_resp_yumi_i;
    aux_resp_yumi_o  = ~reset_i & ~empty & ~head_host & io_resp_yumi_i;
    deq              = ~reset_i & io_resp_yumi_i;
  end

`ifdef BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN
  logic entry_host;
  logic entry_aux;
`endif

  bp_gateway_io_splitter_tracker #(
    .els_p(max_outstanding_p)
  ) tracker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enq_v_i     (enq),
    .enq_dest_i  (dest),
    .deq_v_i     (deq),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
`ifdef BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN
    ,
    .entry_host_o(entry_host),
    .entry_aux_o (entry_aux)
`endif
  );

`ifdef BP_GATEWAY_IO_SPLITTER_ERR_CHECK_EN
  logic stray_host;
  logic stray_aux;
  logic bad_yumi;
  logic overflow;
  logic error_r;

  // Protocol violations: orphan responses, yumi without valid, or a command
  // aimed at a device that already owns every tracker slot.
  always_comb begin
    stray_host = host_resp_v_i & ~entry_host;
    stray_aux  = aux_resp_v_i & ~entry_aux;
    bad_yumi   = io_resp_yumi_i & ~io_resp_v_o;
    overflow   = io_cmd_v_i & full &
                 ((dest == e_dest_host) ? (entry_host & ~entry_aux)
                                        : (entry_aux & ~entry_host));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i)                                              error_r <= 1'b0;
    else if (stray_host | stray_aux | bad_yumi | overflow)    error_r <= 1'b1;
  end

  // Simulation report of each violation with its time.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (stray_host) $error("io_splitter: host response with no pending host entry at %0t", $time);
      if (stray_aux)  $error("io_splitter: aux response with no pending aux entry at %0t", $time);
      if (bad_yumi)   $error("io_splitter: io_resp_yumi_i without io_resp_v_o at %0t", $time);
      if (overflow)   $error("io_splitter: command to device with all slots pending at %0t", $time);
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
